pll_lock_reset_seq: RTL and testbench

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

---
 rtl/pll_lock_reset_seq.sv | 176 +++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: brings a PLL out of reset, waits for a filtered lock,
// then releases a chain of downstream reset domains one after another.
// Lock loss or a forced restart drops every domain and starts over.
module pll_lock_reset_seq #(
  parameter int NUM_RST        = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int STAGGER        = 8,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock_i,
  input  logic               force_reset_i,
  output logic               pll_reset_o,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               ready_o,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   retry_cnt_o,
  output logic [CNT_W-1:0]   loss_cnt_o
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  // Cycle index of the last domain release; one cycle later the block is running.
  localparam int                 LAST_K    = (NUM_RST - 1) * STAGGER;
  localparam logic [NUM_RST-1:0] FIRST_REL = NUM_RST'(1);
  localparam logic [NUM_RST-1:0] ALL_LOW   = {NUM_RST{1'b0}};

  state_e             r_state;
  logic [31:0]        r_cnt;
  logic               r_sync1;
  logic               r_sync2;
  logic               w_lock_s;
  logic [NUM_RST-1:0] w_rel_mask;

  // Event counters stick at all-ones so a long-lived fault history never wraps to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign w_lock_s = r_sync2;
  assign state_o  = r_state;

  // Two-flop synchroniser: PLL lock is asynchronous to the reference clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_lock_i;
      r_sync2 <= r_sync1;
    end
  end

  // Domains that must be released by the next RELEASE cycle (k+1 >= i*STAGGER).
  always_comb begin
    w_rel_mask = ALL_LOW;
    for (int i = 0; i < NUM_RST; i++) begin
      if ((r_cnt + 32'd1) >= 32'(i * STAGGER)) begin
        w_rel_mask[i] = 1'b1;
      end else begin
        w_rel_mask[i] = 1'b0;
      end
    end
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= 32'd0;
      pll_reset_o <= 1'b1;
      rst_n_o     <= ALL_LOW;
      ready_o     <= 1'b0;
      retry_cnt_o <= {CNT_W{1'b0}};
      loss_cnt_o  <= {CNT_W{1'b0}};
    end else if (force_reset_i && (r_state != S_PLL_RST)) begin
      // Forced restart wins over a simultaneous lock loss and is not counted.
      r_state     <= S_PLL_RST;
      r_cnt       <= 32'd0;
      pll_reset_o <= 1'b1;
      rst_n_o     <= ALL_LOW;
      ready_o     <= 1'b0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          pll_reset_o <= 1'b1;
          rst_n_o     <= ALL_LOW;
          ready_o     <= 1'b0;
          if (r_cnt == 32'(PLL_RST_CYCLES - 1)) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= 32'd0;
            pll_reset_o <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= S_FILTER;
            r_cnt   <= 32'd0;
          end else if (r_cnt == 32'(LOCK_TIMEOUT - 1)) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= 32'd0;
            pll_reset_o <= 1'b1;
            retry_cnt_o <= sat_inc(retry_cnt_o);
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_FILTER: begin
          if (!w_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= 32'd0;
          end else if (r_cnt == 32'(LOCK_FILTER - 1)) begin
            // Domain 0 comes out of reset on the first RELEASE cycle.
            r_state <= S_RELEASE;
            r_cnt   <= 32'd0;
            rst_n_o <= FIRST_REL;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RELEASE: begin
          if (!w_lock_s) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= 32'd0;
            pll_reset_o <= 1'b1;
            rst_n_o     <= ALL_LOW;
            ready_o     <= 1'b0;
            loss_cnt_o  <= sat_inc(loss_cnt_o);
          end else if (r_cnt == 32'(LAST_K)) begin
            r_state <= S_RUN;
            r_cnt   <= 32'd0;
            ready_o <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 32'd1;
            rst_n_o <= w_rel_mask;
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= 32'd0;
            pll_reset_o <= 1'b1;
            rst_n_o     <= ALL_LOW;
            ready_o     <= 1'b0;
            loss_cnt_o  <= sat_inc(loss_cnt_o);
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_PLL_RST;
          r_cnt       <= 32'd0;
          pll_reset_o <= 1'b1;
          rst_n_o     <= ALL_LOW;
          ready_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed stimulus pushes the expected sequence of
// output tuples (with the dwell of each tuple in cycles); a monitor pops one
// entry every time the DUT outputs change and compares.
module tb_pll_lock_reset_seq;

  localparam int NR = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pll_lock_i = 1'b1;
  logic          force_reset_i = 1'b0;
  logic          pll_reset_o;
  logic [NR-1:0] rst_n_o;
  logic          ready_o;
  logic [2:0]    state_o;
  logic [CW-1:0] retry_cnt_o;
  logic [CW-1:0] loss_cnt_o;

  typedef struct packed {
    logic [11:0] val;
    logic [31:0] gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  pll_lock_reset_seq #(
    .NUM_RST(NR), .PLL_RST_CYCLES(4), .LOCK_FILTER(4),
    .LOCK_TIMEOUT(32), .STAGGER(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .force_reset_i(force_reset_i),
    .pll_reset_o(pll_reset_o), .rst_n_o(rst_n_o), .ready_o(ready_o), .state_o(state_o),
    .retry_cnt_o(retry_cnt_o), .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) cyc <= cyc + 1;

  // Tuple layout: state | pll_reset | rst_n_o | ready | retry | loss
  function automatic logic [11:0] mk(input int st, input int pr, input logic [2:0] rn,
                                     input int rdy, input int rt, input int ls);
    return {3'(st), 1'(pr), rn, 1'(rdy), 2'(rt), 2'(ls)};
  endfunction

  task automatic push(input logic [11:0] v, input int g);
    exp_t e;
    e.val = v;
    e.gap = 32'(g);
    q.push_back(e);
  endtask

  // FILTER (after fg cycles of WAIT_LOCK), staggered release 001/011/111, RUN.
  task automatic push_tail(input int rt, input int ls, input int fg);
    push(mk(2, 0, 3'b000, 0, rt, ls), fg);
    push(mk(3, 0, 3'b001, 0, rt, ls), 4);
    push(mk(3, 0, 3'b011, 0, rt, ls), 2);
    push(mk(3, 0, 3'b111, 0, rt, ls), 2);
    push(mk(4, 0, 3'b111, 1, rt, ls), 1);
  endtask

  task automatic push_bringup(input int rt, input int ls, input int g);
    push(mk(1, 0, 3'b000, 0, rt, ls), g);
    push_tail(rt, ls, 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain %s: %0d expected changes still pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic force_pulse();
    @(posedge clk);
    #1 force_reset_i = 1'b1;
    @(posedge clk);
    #1 force_reset_i = 1'b0;
  endtask

  task automatic drop_lock();
    @(posedge clk);
    #1 pll_lock_i = 1'b0;
  endtask

  // Monitor: every output change pops one expected tuple and its dwell.
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    bit          first;
    int          last;
    int          gap;
    exp_t        e;
    first = 1'b1;
    last  = 0;
    prev  = 12'd0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      cur = {state_o, pll_reset_o, rst_n_o, ready_o, retry_cnt_o, loss_cnt_o};
      if (first || cur !== prev) begin
        gap = cyc - last;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %b, required no change (st|pr|rst_n|rdy|retry|loss)", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.val) begin
            errors++;
            $display("FAIL outputs: got %b required %b (st|pr|rst_n|rdy|retry|loss)", cur, e.val);
          end
          if (e.gap != 32'd0) begin
            checks++;
            if (32'(gap) != e.gap) begin
              errors++;
              $display("FAIL dwell before %b: got %0d cycles required %0d", e.val, gap, e.gap);
            end
          end
        end
        prev  = cur;
        last  = cyc;
        first = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    // Reset state, then clean bring-up with lock held high.
    push(mk(0, 1, 3'b000, 0, 0, 0), 0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    push_bringup(0, 0, 0);
    wait_drain(30, "bringup");

    // Lock loss in RUN: all domains low within the synchroniser latency.
    push(mk(0, 1, 3'b000, 0, 0, 1), 0);
    drop_lock();
    wait_drain(4, "loss_latency");
    pll_lock_i = 1'b1;
    push_bringup(0, 1, 4);
    wait_drain(30, "recover_after_loss");

    // Force coinciding with lock loss in RUN: no loss count.
    push(mk(0, 1, 3'b000, 0, 0, 1), 0);
    push_bringup(0, 1, 4);
    drop_lock();
    @(posedge clk);
    @(posedge clk);
    #1 force_reset_i = 1'b1;
    @(posedge clk);
    #1 force_reset_i = 1'b0;
    pll_lock_i = 1'b1;
    wait_drain(30, "force_with_loss");

    // Force while RELEASE shows 011.
    push(mk(0, 1, 3'b000, 0, 0, 1), 0);
    push(mk(1, 0, 3'b000, 0, 0, 1), 4);
    push(mk(2, 0, 3'b000, 0, 0, 1), 1);
    push(mk(3, 0, 3'b001, 0, 0, 1), 4);
    push(mk(3, 0, 3'b011, 0, 0, 1), 2);
    push(mk(0, 1, 3'b000, 0, 0, 1), 1);
    push_bringup(0, 1, 4);
    force_pulse();
    repeat (11) @(posedge clk);
    #1 force_reset_i = 1'b1;
    @(posedge clk);
    #1 force_reset_i = 1'b0;
    wait_drain(40, "force_in_release");

    // One-cycle lock glitch in the fourth FILTER cycle.
    push(mk(0, 1, 3'b000, 0, 0, 1), 0);
    push(mk(1, 0, 3'b000, 0, 0, 1), 4);
    push(mk(2, 0, 3'b000, 0, 0, 1), 1);
    push_bringup(0, 1, 4);
    force_pulse();
    repeat (6) @(posedge clk);
    #1 pll_lock_i = 1'b0;
    @(posedge clk);
    #1 pll_lock_i = 1'b1;
    wait_drain(40, "filter_glitch");

    // Lock held low: retries every 36 cycles, retry count saturates at 3.
    push(mk(0, 1, 3'b000, 0, 0, 2), 0);
    drop_lock();
    wait_drain(5, "loss_to_retry");
    for (int i = 1; i <= 4; i++) begin
      push(mk(1, 0, 3'b000, 0, (i - 1 > 3) ? 3 : i - 1, 2), 4);
      push(mk(0, 1, 3'b000, 0, (i > 3) ? 3 : i, 2), 32);
    end
    push(mk(1, 0, 3'b000, 0, 3, 2), 4);
    wait_drain(200, "retry_train");
    pll_lock_i = 1'b1;
    push_tail(3, 2, 3);
    wait_drain(30, "recover_after_retries");

    // Loss count saturates at 3.
    for (int j = 0; j < 2; j++) begin
      push(mk(0, 1, 3'b000, 0, 3, 3), 0);
      drop_lock();
      wait_drain(5, "loss_sat");
      pll_lock_i = 1'b1;
      push_bringup(3, 3, 4);
      wait_drain(30, "loss_sat_recover");
    end

    // Asynchronous reset in RELEASE, away from any clock edge.
    push(mk(0, 1, 3'b000, 0, 3, 3), 0);
    push(mk(1, 0, 3'b000, 0, 3, 3), 4);
    push(mk(2, 0, 3'b000, 0, 3, 3), 1);
    push(mk(3, 0, 3'b001, 0, 3, 3), 4);
    push(mk(3, 0, 3'b011, 0, 3, 3), 2);
    push(mk(0, 1, 3'b000, 0, 0, 0), 0);
    force_pulse();
    repeat (11) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2;
    wait_drain(0, "async_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    push_bringup(0, 0, 0);
    wait_drain(30, "bringup_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
